// File: rtl/row_seq_ctrl.sv
// ---------------------------------------------------------------------------
// row_seq_ctrl
//   Runs a length-K dot product on one 3-lane ROW_Element. Operands are read
//   from the x/w operand buffers three at a time (one "group"). Each group is
//   sent to the row element, and its three lane results are added into a
//   signed running sum.
//
// Ports
//   clk                      clock, all state on posedge
//   rst                      asynchronous reset, active low
//   start, len, base_addr    command: element count K and first group address
//   busy, done, error        status: done is a one-cycle pulse; error (timeout)
//                            is held until the next accepted start
//   result                   signed dot product, valid from done until the
//                            next accepted start
//   rd_en, rd_addr           operand-buffer read (same address for x and w)
//   x_rdata, w_rdata         packed {e2,e1,e0}, valid the cycle after rd_en
//   row_start                one-cycle launch pulse to the row element
//   x0..x2, w0..w2, acc_in   operands to the row element (acc_in tied to 0)
//   row_done, acc0..2_out    row element completion and lane results
// ---------------------------------------------------------------------------
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | rd_en high, rd_addr = base + group index
// RDWAIT    | read data on the bus; capture it, zeroing lanes past K
// LAUNCH    | row_start pulse, clear timeout counter
// WAIT_DONE | wait for row_done, give up after TMO cycles since launch
// ACCUM     | add the three lane results, next group or finish
// FINISH    | done pulse, result published
// ---------------------------------------------------------------------------
module row_seq_ctrl #(
  parameter int DW    = 16,
  parameter int ACC_W = 40,
  parameter int KW    = 8,
  parameter int AW    = 6,
  parameter int TMO   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KW-1:0]           len,
  input  logic [AW-1:0]           base_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic signed [ACC_W-1:0] result,
  output logic                    rd_en,
  output logic [AW-1:0]           rd_addr,
  input  logic [3*DW-1:0]         x_rdata,
  input  logic [3*DW-1:0]         w_rdata,
  output logic                    row_start,
  output logic [DW-1:0]           x0,
  output logic [DW-1:0]           x1,
  output logic [DW-1:0]           x2,
  output logic [DW-1:0]           w0,
  output logic [DW-1:0]           w1,
  output logic [DW-1:0]           w2,
  output logic [2*DW-1:0]         acc_in,
  input  logic                    row_done,
  input  logic [2*DW-1:0]         acc0_out,
  input  logic [2*DW-1:0]         acc1_out,
  input  logic [2*DW-1:0]         acc2_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_RDWAIT = 3'd2;
  localparam logic [2:0] S_LAUNCH = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_ACCUM  = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  localparam int TW = (TMO > 2) ? $clog2(TMO) : 1;
  // The launch cycle counts as the first cycle of waiting, so WAIT_DONE gives
  // up on its (TMO-1)th cycle and done lands exactly TMO cycles after launch.
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 2);
  localparam int GW = KW + 2;  // wide enough for 3*g + 3

  logic [2:0]              state;
  logic [KW-1:0]           len_q;
  logic [AW-1:0]           base_q;
  logic [KW-1:0]           grp;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] result_q;
  logic                    error_q;
  logic [TW-1:0]           tmo_cnt;
  logic [DW-1:0]           x_q [3];
  logic [DW-1:0]           w_q [3];

  logic [GW-1:0]           len_ext;
  logic [GW-1:0]           grp3;
  logic [2:0]              lane_ok;
  logic                    last_grp;
  logic [DW-1:0]           x_in [3];
  logic [DW-1:0]           w_in [3];
  logic signed [ACC_W-1:0] ext0, ext1, ext2, acc_nxt;
  logic [AW-1:0]           grp_lo;

  // Group bookkeeping: element index of lane j in group g is 3g+j.
  always_comb begin
    len_ext  = GW'(len_q);
    grp3     = GW'(grp) + GW'(grp) + GW'(grp);
    lane_ok  = '0;
    for (int j = 0; j < 3; j++) begin
      lane_ok[j] = len_ext > (grp3 + GW'(j));
    end
    last_grp = (grp3 + GW'(3)) >= len_ext;
  end

  // Lanes past the end of the vector are forced to zero on both operands so
  // whatever the buffer holds there cannot leak into the sum.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      x_in[j] = '0;
      w_in[j] = '0;
      if (lane_ok[j]) begin
        x_in[j] = x_rdata[j*DW +: DW];
        w_in[j] = w_rdata[j*DW +: DW];
      end
    end
  end

  always_comb begin
    ext0    = ACC_W'($signed(acc0_out));
    ext1    = ACC_W'($signed(acc1_out));
    ext2    = ACC_W'($signed(acc2_out));
    acc_nxt = acc + ext0 + ext1 + ext2;  // wraps modulo 2^ACC_W
  end

  // Group index truncated to the buffer address width: rd_addr wraps.
  always_comb grp_lo = AW'(grp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      base_q   <= '0;
      grp      <= '0;
      acc      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      tmo_cnt  <= '0;
      for (int j = 0; j < 3; j++) begin
        x_q[j] <= '0;
        w_q[j] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            error_q  <= 1'b0;
            acc      <= '0;
            result_q <= '0;
            grp      <= '0;
            if (len != '0) begin
              len_q  <= len;
              base_q <= base_addr;
              state  <= S_FETCH;
            end else begin
              state  <= S_FINISH;
            end
          end
        end
        S_FETCH: begin
          state <= S_RDWAIT;
        end
        S_RDWAIT: begin
          for (int j = 0; j < 3; j++) begin
            x_q[j] <= x_in[j];
            w_q[j] <= w_in[j];
          end
          state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (row_done) begin
            state <= S_ACCUM;
          end else if (tmo_cnt == TMO_LAST) begin
            error_q  <= 1'b1;
            result_q <= acc;
            state    <= S_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          acc <= acc_nxt;
          if (last_grp) begin
            result_q <= acc_nxt;
            state    <= S_FINISH;
          end else begin
            grp   <= grp + 1'b1;
            state <= S_FETCH;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE) && (state != S_FINISH);
  assign done      = (state == S_FINISH);
  assign error     = error_q;
  assign result    = result_q;
  assign rd_en     = (state == S_FETCH);
  assign rd_addr   = rd_en ? (base_q + grp_lo) : '0;
  assign row_start = (state == S_LAUNCH);
  assign x0        = x_q[0];
  assign x1        = x_q[1];
  assign x2        = x_q[2];
  assign w0        = w_q[0];
  assign w1        = w_q[1];
  assign w2        = w_q[2];
  assign acc_in    = '0;

endmodule

// File: tb/tb_row_seq_ctrl.sv
module tb_row_seq_ctrl;

  localparam int DW    = 16;
  localparam int ACC_W = 40;
  localparam int KW    = 8;
  localparam int AW    = 6;
  localparam int TMO   = 64;
  localparam int NADDR = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [KW-1:0]     len;
  logic [AW-1:0]     base_addr;
  logic              busy, done, error;
  logic [ACC_W-1:0]  result;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [3*DW-1:0]   x_rdata, w_rdata;
  logic              row_start;
  logic [DW-1:0]     x0, x1, x2, w0, w1, w2;
  logic [2*DW-1:0]   acc_in;
  logic              row_done;
  logic [2*DW-1:0]   acc0_out, acc1_out, acc2_out;

  row_seq_ctrl #(.DW(DW), .ACC_W(ACC_W), .KW(KW), .AW(AW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .base_addr(base_addr),
    .busy(busy), .done(done), .error(error), .result(result),
    .rd_en(rd_en), .rd_addr(rd_addr), .x_rdata(x_rdata), .w_rdata(w_rdata),
    .row_start(row_start), .x0(x0), .x1(x1), .x2(x2), .w0(w0), .w1(w1), .w2(w2),
    .acc_in(acc_in), .row_done(row_done),
    .acc0_out(acc0_out), .acc1_out(acc1_out), .acc2_out(acc2_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Operand buffer contents, indexed [group address][lane].
  logic signed [DW-1:0] xm [NADDR][3];
  logic signed [DW-1:0] wm [NADDR][3];

  // Synchronous-read buffer: data appears only in the cycle after rd_en;
  // every other cycle the bus carries junk.
  bit            rd_pend = 1'b0;
  logic [AW-1:0] rd_pa   = '0;
  always @(negedge clk) begin
    if (rd_pend) begin
      x_rdata = {xm[rd_pa][2], xm[rd_pa][1], xm[rd_pa][0]};
      w_rdata = {wm[rd_pa][2], wm[rd_pa][1], wm[rd_pa][0]};
    end else begin
      x_rdata = 48'({$urandom(), $urandom()});
      w_rdata = 48'({$urandom(), $urandom()});
    end
    rd_pend = rd_en;
    rd_pa   = rd_addr;
  end

  // Row element: lane results are junk until row_done, then x*w held until
  // the next launch. Optionally a stray row_done in the launch cycle, and
  // optionally one launch that never completes.
  int row_lat     = 2;
  bit stray_en    = 1'b0;
  int tmo_grp     = -1;
  int launch_idx  = 0;
  int last_launch = 0;
  int row_cnt     = 0;
  logic [6*DW-1:0]        op_snap;
  logic signed [2*DW-1:0] p0, p1, p2;

  always @(negedge clk) begin
    row_done = 1'b0;
    if (!rst) begin
      row_cnt = 0;
    end else begin
      if (row_cnt > 0) begin
        row_cnt--;
        if (row_cnt == 0) begin
          row_done = 1'b1;
          acc0_out = p0;
          acc1_out = p1;
          acc2_out = p2;
          check("operands_held", ({x0, x1, x2, w0, w1, w2} == op_snap), 1);
        end
      end
      if (row_start) begin
        p0 = $signed(x0) * $signed(w0);
        p1 = $signed(x1) * $signed(w1);
        p2 = $signed(x2) * $signed(w2);
        op_snap  = {x0, x1, x2, w0, w1, w2};
        acc0_out = $urandom();
        acc1_out = $urandom();
        acc2_out = $urandom();
        row_cnt  = (launch_idx == tmo_grp) ? 0 : row_lat;
        row_done = stray_en && ($urandom_range(0, 1) == 1);
        last_launch = cyc;
        launch_idx++;
      end
    end
  end

  typedef struct {
    logic [ACC_W-1:0] res;
    bit               err;
    int               nrd;
    int               start_cyc;
    bit               chk_zero;
    bit               chk_tmo;
  } exp_t;

  exp_t          exp_q [$];
  logic [AW-1:0] addr_q [$];
  exp_t          mon_e;
  int            n_rd = 0;
  int            n_rs = 0;

  // Monitor: pops the scoreboard whenever the DUT reads or completes.
  always @(negedge clk) begin
    if (rst) begin
      if (rd_en) begin
        n_rd++;
        check("rd_expected", (addr_q.size() != 0), 1);
        if (addr_q.size() != 0) check("rd_addr", rd_addr, addr_q.pop_front());
      end
      if (row_start) n_rs++;
      if (done) begin
        check("done_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("result", result, mon_e.res);
          check("error", error, mon_e.err);
          check("busy_at_done", busy, 0);
          check("rd_count", n_rd, mon_e.nrd);
          check("row_start_count", n_rs, mon_e.nrd);
          if (mon_e.chk_zero) check("k0_done_latency", cyc - mon_e.start_cyc, 1);
          if (mon_e.chk_tmo)  check("timeout_latency", cyc - last_launch, TMO);
        end
        n_rd = 0;
        n_rs = 0;
      end
    end
  end

  task automatic set_grp(input int a, input int xa, input int xb, input int xc,
                         input int wa, input int wb, input int wc);
    xm[a][0] = DW'(xa); xm[a][1] = DW'(xb); xm[a][2] = DW'(xc);
    wm[a][0] = DW'(wa); wm[a][1] = DW'(wb); wm[a][2] = DW'(wc);
  endtask

  task automatic fill_rand(input int k, input int b);
    for (int g = 0; g < (k + 2) / 3; g++) begin
      for (int j = 0; j < 3; j++) begin
        xm[(b + g) % NADDR][j] = DW'($urandom());
        wm[(b + g) % NADDR][j] = DW'($urandom());
      end
    end
  endtask

  // Reference: sum of x[i]*w[i] over the first K elements, taken group by
  // group from the buffer; a timeout at group tg keeps only groups < tg.
  task automatic issue(input int k, input int b, input int tg);
    longint s = 0;
    int     ngrp, nact, a;
    exp_t   e;
    ngrp = (k + 2) / 3;
    nact = (tg >= 0) ? tg + 1 : ngrp;
    for (int g = 0; g < nact; g++) begin
      a = (b + g) % NADDR;
      addr_q.push_back(AW'(a));
      if (tg < 0 || g < tg) begin
        for (int j = 0; j < 3; j++) begin
          if (3 * g + j < k) s += longint'(xm[a][j]) * longint'(wm[a][j]);
        end
      end
    end
    e.res      = ACC_W'(s);
    e.err      = (tg >= 0);
    e.nrd      = nact;
    e.chk_zero = (k == 0);
    e.chk_tmo  = (tg >= 0);
    @(negedge clk);
    tmo_grp     = tg;
    launch_idx  = 0;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    start     = 1'b1;
    len       = KW'(k);
    base_addr = AW'(b);
    @(negedge clk);
    start     = 1'b0;
    len       = KW'($urandom());
    base_addr = AW'($urandom());
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completes"}, exp_q.size(), 0);
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic check_outs_zero(input string name);
    check({name, "_ctrl"}, {busy, done, error, rd_en, row_start}, 0);
    check({name, "_result"}, result, 0);
    check({name, "_ops"}, |{rd_addr, x0, x1, x2, w0, w1, w2, acc_in}, 0);
  endtask

  initial begin
    int n, k, b, tg, ndone;
    rst = 1'b0; start = 1'b0; len = '0; base_addr = '0;
    row_done = 1'b0; acc0_out = '0; acc1_out = '0; acc2_out = '0;
    x_rdata = '0; w_rdata = '0;
    repeat (3) @(negedge clk);
    check_outs_zero("reset");
    rst = 1'b1;

    set_grp(5, 3, -2, 7, 4, 5, -1);
    issue(3, 5, -1);
    wait_idle("k3");

    set_grp(10, 3, -2, 7, 4, 5, -1);
    set_grp(11, 2, 2, 2, 10, -3, 4);
    issue(6, 10, -1);
    wait_idle("k6");

    set_grp(20, 3, -2, 7, 4, 5, -1);
    set_grp(21, 5, 9, 9, 2, 9, 9);
    issue(4, 20, -1);
    wait_idle("k4_mask");

    issue(0, 0, -1);
    wait_idle("k0");

    row_lat = 1; stray_en = 1'b1;
    set_grp(63, 3, -2, 7, 4, 5, -1);
    set_grp(0, 2, 2, 2, 10, -3, 4);
    issue(6, 63, -1);
    wait_idle("addr_wrap");
    row_lat = 2; stray_en = 1'b0;

    set_grp(30, 1, 1, 1, 1, 1, 1);
    issue(3, 30, 0);
    wait_idle("timeout_g0");
    set_grp(40, 3, -2, 7, 4, 5, -1);
    set_grp(41, 1, 1, 1, 1, 1, 1);
    issue(6, 40, 1);
    wait_idle("timeout_g1");
    issue(3, 5, -1);
    wait_idle("after_timeout");

    // start while busy, then start in the done cycle itself
    issue(3, 5, -1);
    repeat (4) @(negedge clk);
    start = 1'b1; len = KW'(9); base_addr = AW'(7);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    start = 1'b1; len = KW'(3); base_addr = AW'(5);
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", busy, 0);
    wait_idle("busy_start");

    // reset in the middle of WAIT_DONE
    row_lat = 30;
    issue(3, 5, -1);
    repeat (6) @(negedge clk);
    check("in_wait_done", {busy, rd_en, row_start}, 3'b100);
    start = 1'b1; len = KW'(3);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    #1;
    check_outs_zero("mid_reset");
    exp_q.delete();
    addr_q.delete();
    n_rd = 0;
    n_rs = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    row_lat = 2;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_done_after_reset", ndone, 0);
    issue(3, 5, -1);
    wait_idle("post_reset_k3");

    for (int i = 0; i < 14; i++) begin
      k  = (i == 0) ? 255 : int'($urandom_range(0, 30));
      b  = (i == 0) ? 60 : int'($urandom_range(0, NADDR - 1));
      tg = -1;
      if (k > 0 && $urandom_range(0, 5) == 0) tg = int'($urandom_range(0, (k + 2) / 3 - 1));
      row_lat  = int'($urandom_range(1, 4));
      stray_en = ($urandom_range(0, 1) == 1);
      fill_rand(k, b);
      issue(k, b, tg);
      wait_idle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
